sdram_init_param: RTL and testbench

Parametrised successor to the fixed SDRAM power-up sequencer. It issues the JEDEC init sequence to a W9825G6KH-class SDR SDRAM: power-up NOP wait, PRECHARGE ALL, N× AUTO REFRESH, then LOAD MODE REGISTER. All timings, the refresh count, address width and mode-register fields are generics. It adds a re-initialisation request, so the arbiter can re-run the sequence without a reset. It sits in the controller's clk_100m domain and feeds the command mux ahead of the arbiter.

---
 rtl/sdram_init_param_pkg.sv | 40 ++++
 rtl/sdram_init_param_if.sv | 22 ++
 rtl/sdram_init_param.sv | 147 ++++++++++++++
 tb/tb_sdram_init_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_init_param_pkg.sv
// Shared SDR SDRAM definitions: command encodings, mode-register layout and burst codes.
// The mode_word helper is reused wherever the mode register is (re)programmed.
package sdram_init_param_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    typedef enum logic [3:0] {
        CmdLoadMode  = 4'b0000,
        CmdAref      = 4'b0001,
        CmdPrecharge = 4'b0010,
        CmdActive    = 4'b0011,
        CmdWrite     = 4'b0100,
        CmdRead      = 4'b0101,
        CmdBurstStop = 4'b0110,
        CmdNop       = 4'b0111
    } sdram_cmd_e;

    localparam int unsigned A10_BIT = 10;
    localparam int unsigned BL_LSB  = 0;
    localparam int unsigned BT_BIT  = 3;
    localparam int unsigned CL_LSB  = 4;
    localparam int unsigned WB_BIT  = 9;

    localparam logic [2:0] BL_1    = 3'b000;
    localparam logic [2:0] BL_2    = 3'b001;
    localparam logic [2:0] BL_4    = 3'b010;
    localparam logic [2:0] BL_8    = 3'b011;
    localparam logic [2:0] BL_FULL = 3'b111;

    function automatic logic [9:0] mode_word(input logic [2:0] cl, input logic [2:0] bl,
                                             input logic bt, input logic wb);
        logic [9:0] w_mw;
        w_mw                 = '0;
        w_mw[BL_LSB +: 3]    = bl;
        w_mw[BT_BIT]         = bt;
        w_mw[CL_LSB +: 3]    = cl;
        w_mw[WB_BIT]         = wb;
        return w_mw;
    endfunction

endpackage

// File: rtl/sdram_init_param_if.sv
// Init-sequencer command bus: the sequencer is master, the command mux/arbiter is slave.
interface sdram_init_param_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BANK_W = 2
);
    logic              init_req;
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              init_busy;

    modport master (
        input  init_req,
        output init_cmd, init_bank, init_addr, init_end, init_busy
    );

    modport slave (
        output init_req,
        input  init_cmd, init_bank, init_addr, init_end, init_busy
    );
endinterface

// File: rtl/sdram_init_param.sv
// Parametrised SDR SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, with a re-init request that skips the power wait.
module sdram_init_param
    import sdram_init_param_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned BANK_W      = 2,
    parameter int unsigned T_POWER     = 20000,
    parameter int unsigned T_RP        = 2,
    parameter int unsigned T_RFC       = 7,
    parameter int unsigned T_MRD       = 3,
    parameter int unsigned AREF_NUM    = 8,
    parameter int unsigned CAS_LAT     = 3,
    parameter logic [2:0]  BURST_LEN   = BL_FULL,
    parameter int unsigned BURST_TYPE  = 0,
    parameter int unsigned WRITE_BURST = 0
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    sdram_init_param_if.master  init_if
);

    localparam int unsigned T_MAX01 = (T_POWER > T_RP) ? T_POWER : T_RP;
    localparam int unsigned T_MAX23 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int unsigned T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);
    localparam int unsigned REF_W   = $clog2(AREF_NUM + 1);

    typedef enum logic [2:0] {
        StWaitPower, StPrecharge, StWaitTrp, StAref,
        StWaitTrfc, StLoadMode, StWaitTmrd, StDone
    } state_e;

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [REF_W-1:0]  r_aref, w_aref_d, w_aref_inc;
    logic              r_armed, w_armed_d;
    logic [3:0]        r_cmd, w_cmd;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_end, w_end;
    logic [CNT_W:0]    w_elapsed;

    // r_cnt holds cycles elapsed since the last command; power wait counts from reset release
    assign w_elapsed  = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_aref_inc = r_aref + REF_W'(1);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_aref_d  = r_aref;
        w_armed_d = r_armed | ~init_if.init_req;
        unique case (r_state)
            StWaitPower: begin
                if (r_cnt == CNT_W'(T_POWER)) begin
                    w_state_d = StPrecharge;
                    w_aref_d  = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StPrecharge: begin
                w_cnt_d   = CNT_W'(1);
                w_state_d = (T_RP == 1) ? StAref : StWaitTrp;
            end
            StWaitTrp: begin
                w_cnt_d = w_elapsed[CNT_W-1:0];
                if (w_elapsed == (CNT_W + 1)'(T_RP)) w_state_d = StAref;
            end
            StAref: begin
                w_aref_d = w_aref_inc;
                w_cnt_d  = CNT_W'(1);
                if (T_RFC != 1) w_state_d = StWaitTrfc;
                else w_state_d = (w_aref_inc < REF_W'(AREF_NUM)) ? StAref : StLoadMode;
            end
            StWaitTrfc: begin
                w_cnt_d = w_elapsed[CNT_W-1:0];
                if (w_elapsed == (CNT_W + 1)'(T_RFC)) begin
                    w_state_d = (r_aref < REF_W'(AREF_NUM)) ? StAref : StLoadMode;
                end
            end
            StLoadMode: begin
                w_cnt_d   = CNT_W'(1);
                w_state_d = (T_MRD == 1) ? StDone : StWaitTmrd;
            end
            StWaitTmrd: begin
                w_cnt_d = w_elapsed[CNT_W-1:0];
                if (w_elapsed == (CNT_W + 1)'(T_MRD)) w_state_d = StDone;
            end
            StDone: begin
                // A held request fires once, then needs to be seen low before re-arming
                if (init_if.init_req && r_armed) begin
                    w_state_d = StPrecharge;
                    w_armed_d = 1'b0;
                    w_aref_d  = '0;
                end
            end
            default: w_state_d = StWaitPower;
        endcase
    end

    always_comb begin
        w_cmd  = CmdNop;
        w_addr = '0;
        w_end  = 1'b0;
        case (w_state_d)
            StPrecharge: begin
                w_cmd           = CmdPrecharge;
                w_addr[A10_BIT] = 1'b1;
            end
            StAref:     w_cmd = CmdAref;
            StLoadMode: begin
                w_cmd  = CmdLoadMode;
                w_addr = ADDR_W'(mode_word(3'(CAS_LAT), BURST_LEN, 1'(BURST_TYPE),
                                           1'(WRITE_BURST)));
            end
            StDone:     w_end = 1'b1;
            default:    w_cmd = CmdNop;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= StWaitPower;
            r_cnt   <= '0;
            r_aref  <= '0;
            r_armed <= 1'b1;
            r_cmd   <= CmdNop;
            r_addr  <= '0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_aref  <= w_aref_d;
            r_armed <= w_armed_d;
            r_cmd   <= w_cmd;
            r_addr  <= w_addr;
            r_end   <= w_end;
        end
    end

    assign init_if.init_cmd  = r_cmd;
    assign init_if.init_bank = '0;
    assign init_if.init_addr = r_addr;
    assign init_if.init_end  = r_end;
    assign init_if.init_busy = ~r_end;

endmodule

// File: tb/tb_sdram_init_param.sv
// Scoreboard bench: a default-timing sequencer and a short-timing sequencer with a custom
// mode word; expected command events are queued at stimulus time and matched on output.
module tb_sdram_init_param;
    import sdram_init_param_pkg::*;

    localparam logic [3:0] EV_END = 4'hF;
    // short-timing instance
    localparam int B_TP = 10, B_TRP = 3, B_TRFC = 5, B_TMRD = 2, B_NARF = 2;
    localparam logic [12:0] B_MODE = 13'h22A;
    localparam logic [12:0] A_MODE = 13'h037;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [12:0] addr;
    } ev_t;

    ev_t  q_a[$];
    ev_t  q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic clk = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    int   cyc_a = -1;
    int   cyc_b = -1;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always #5 clk = ~clk;

    sdram_init_param_if #(.ADDR_W(13), .BANK_W(2)) if_a ();
    sdram_init_param_if #(.ADDR_W(13), .BANK_W(2)) if_b ();

    sdram_init_param u_dut_a (
        .i_clk   (clk),
        .i_rstn  (rstn_a),
        .init_if (if_a)
    );

    sdram_init_param #(
        .T_POWER(B_TP), .T_RP(B_TRP), .T_RFC(B_TRFC), .T_MRD(B_TMRD), .AREF_NUM(B_NARF),
        .CAS_LAT(2), .BURST_LEN(3'b010), .BURST_TYPE(1), .WRITE_BURST(1)
    ) u_dut_b (
        .i_clk   (clk),
        .i_rstn  (rstn_b),
        .init_if (if_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_ev(input bit sel, input ev_t e);
        if (sel) q_b.push_back(e);
        else q_a.push_back(e);
    endtask

    task automatic push_seq(input bit sel, input int base, input int trp, input int trfc,
                            input int tmrd, input int narf, input logic [12:0] mode);
        ev_t e;
        int  c;
        c = base;
        e.cyc = c; e.cmd = CmdPrecharge; e.addr = 13'h0400; push_ev(sel, e);
        c += trp;
        for (int k = 0; k < narf; k++) begin
            e.cyc = c; e.cmd = CmdAref; e.addr = 13'h0000; push_ev(sel, e);
            c += trfc;
        end
        e.cyc = c; e.cmd = CmdLoadMode; e.addr = mode; push_ev(sel, e);
        c += tmrd;
        e.cyc = c; e.cmd = EV_END; e.addr = 13'h0000; push_ev(sel, e);
    endtask

    task automatic observe(input bit sel, input int cyc, input logic [3:0] cmd,
                           input logic [12:0] addr, input logic [1:0] bank, input logic en,
                           input logic busy, input logic prev);
        ev_t        e;
        logic [3:0] code;
        int         qsz;
        if (cmd == CmdNop && !(en && !prev)) return;
        code = (cmd == CmdNop) ? EV_END : cmd;
        qsz  = sel ? q_b.size() : q_a.size();
        if (qsz == 0) begin
            check_eq(sel ? "b_unexpected_event" : "a_unexpected_event", {28'h0, code},
                     32'hFFFF_FFFF);
            return;
        end
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check_eq(sel ? "b_ev_cycle" : "a_ev_cycle", cyc, e.cyc);
        check_eq(sel ? "b_ev_cmd" : "a_ev_cmd", {28'h0, code}, {28'h0, e.cmd});
        check_eq(sel ? "b_ev_addr" : "a_ev_addr", {19'h0, addr}, {19'h0, e.addr});
        check_eq(sel ? "b_ev_bank" : "a_ev_bank", {30'h0, bank}, 32'h0);
        check_eq(sel ? "b_ev_busy" : "a_ev_busy", {31'h0, busy}, {31'h0, ~en});
        if (code != EV_END) check_eq(sel ? "b_ev_end_low" : "a_ev_end_low", {31'h0, en}, 32'h0);
    endtask

    always @(posedge clk) begin
        cyc_a <= rstn_a ? cyc_a + 1 : -1;
        cyc_b <= rstn_b ? cyc_b + 1 : -1;
    end

    always @(negedge clk) begin
        if (rstn_a) begin
            observe(1'b0, cyc_a, if_a.init_cmd, if_a.init_addr, if_a.init_bank, if_a.init_end,
                    if_a.init_busy, prev_a);
            prev_a <= if_a.init_end;
        end else begin
            prev_a <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstn_b) begin
            observe(1'b1, cyc_b, if_b.init_cmd, if_b.init_addr, if_b.init_bank, if_b.init_end,
                    if_b.init_busy, prev_b);
            prev_b <= if_b.init_end;
        end else begin
            prev_b <= 1'b0;
        end
    end

    task automatic drain(input bit sel, input int budget);
        for (int i = 0; i < budget && (sel ? q_b.size() : q_a.size()) > 0; i++) @(negedge clk);
        check_eq(sel ? "b_events_pending" : "a_events_pending",
                 sel ? q_b.size() : q_a.size(), 0);
    endtask

    task automatic wait_cyc_b(input int c);
        for (int i = 0; i < 1000 && cyc_b != c; i++) @(negedge clk);
        if (cyc_b != c) check_eq("b_wait_cycle_timeout", cyc_b, c);
    endtask

    task automatic reset_b();
        rstn_b = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn_b = 1'b1;
    endtask

    task automatic reinit_b(input bit hold);
        int t;
        @(negedge clk);
        t = cyc_b;
        #2 if_b.init_req = 1'b1;
        push_seq(1'b1, t + 1, B_TRP, B_TRFC, B_TMRD, B_NARF, B_MODE);
        if (!hold) begin
            @(negedge clk);
            #2 if_b.init_req = 1'b0;
        end
        drain(1'b1, 200);
    endtask

    initial begin
        if_a.init_req = 1'b0;
        if_b.init_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd", {28'h0, if_b.init_cmd}, {28'h0, 4'(CmdNop)});
        check_eq("rst_addr", {19'h0, if_b.init_addr}, 32'h0);
        check_eq("rst_bank", {30'h0, if_b.init_bank}, 32'h0);
        check_eq("rst_end", {31'h0, if_b.init_end}, 32'h0);
        check_eq("rst_busy", {31'h0, if_b.init_busy}, 32'h1);
        check_eq("rst_a_cmd", {28'h0, if_a.init_cmd}, {28'h0, 4'(CmdNop)});

        // short timing and custom mode word
        #2 rstn_b = 1'b1;
        push_seq(1'b1, B_TP, B_TRP, B_TRFC, B_TMRD, B_NARF, B_MODE);
        drain(1'b1, 200);

        // re-init by pulse, then by a held request that must fire only once
        repeat (3) @(negedge clk);
        reinit_b(1'b0);
        repeat (2) @(negedge clk);
        reinit_b(1'b1);
        repeat (12) @(negedge clk);
        check_eq("b_hold_no_rearm", {31'h0, if_b.init_end}, 32'h1);
        #2 if_b.init_req = 1'b0;
        repeat (3) @(negedge clk);
        reinit_b(1'b0);

        // request while busy is ignored
        reset_b();
        push_seq(1'b1, B_TP, B_TRP, B_TRFC, B_TMRD, B_NARF, B_MODE);
        wait_cyc_b(15);
        #2 if_b.init_req = 1'b1;
        @(negedge clk);
        #2 if_b.init_req = 1'b0;
        drain(1'b1, 200);
        repeat (10) @(negedge clk);

        // reset during the second AREF
        reset_b();
        push_seq(1'b1, B_TP, B_TRP, B_TRFC, B_TMRD, B_NARF, B_MODE);
        wait_cyc_b(18);
        #2 rstn_b = 1'b0;
        #1;
        check_eq("b_midrst_cmd", {28'h0, if_b.init_cmd}, {28'h0, 4'(CmdNop)});
        check_eq("b_midrst_end", {31'h0, if_b.init_end}, 32'h0);
        check_eq("b_midrst_busy", {31'h0, if_b.init_busy}, 32'h1);
        q_b.delete();
        repeat (3) @(negedge clk);
        #2 rstn_b = 1'b1;
        push_seq(1'b1, B_TP, B_TRP, B_TRFC, B_TMRD, B_NARF, B_MODE);
        drain(1'b1, 200);

        // default timing, full power-up wait
        @(negedge clk);
        #2 rstn_a = 1'b1;
        push_seq(1'b0, 20000, 2, 7, 3, 8, A_MODE);
        drain(1'b0, 21000);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
